// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register target.
// I2C_TARGET_READ_EN adds the read-side states to the state enum.
package i2c_target_pkg;

  localparam int unsigned BIT_CNT_W = 3;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_IGNORE,
    ST_ACK_ADDR,
    ST_PTR,
    ST_ACK_PTR,
    ST_WDATA,
    ST_ACK_WDATA
`ifdef I2C_TARGET_READ_EN
    ,
    ST_RDATA,
    ST_MACK
`endif
  } state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus glitch filter for one I2C line, with
// one-cycle rise/fall pulses aligned to the filtered value changing.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line_raw,
  output logic line_filt,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  // Filtered line follows only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1   <= 1'b1;
      sync_q2   <= 1'b1;
      line_filt <= 1'b1;
      cnt       <= '0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      sync_q1 <= line_raw;
      sync_q2 <= sync_q1;
      rise    <= 1'b0;
      fall    <= 1'b0;
      if (sync_q2 == line_filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        line_filt <= sync_q2;
        rise      <= sync_q2;
        fall      <= ~sync_q2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target with a byte-addressed register file exposed as a flat bus.
// Define I2C_TARGET_READ_EN to compile in the controller-read path.
module i2c_reg_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = 7'h50,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i2c_scl_i,
  input  logic                        i2c_sda_i,
  output logic                        i2c_sda_o,
  output logic                        i2c_sda_t,
  output logic [NUM_REGS*8-1:0]       regs_o,
  output logic                        wr_stb,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr
);

  localparam int unsigned AW = $clog2(NUM_REGS);
`ifdef I2C_TARGET_READ_EN
  localparam int unsigned SHIFT_W = 8;
`else
  localparam int unsigned SHIFT_W = 7;
`endif

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;

  state_e               state, state_n;
  logic [SHIFT_W-1:0]   shift, shift_n;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [AW-1:0]        ptr, ptr_n, wr_addr_n;
  logic                 sda_t_n, wr_stb_n, reg_we;
  logic [7:0]           regs [NUM_REGS];

  logic       scl_was_high, start_det, stop_det, last_bit;
  logic [7:0] byte_in;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk      (clk),
    .rst      (rst),
    .line_raw (i2c_scl_i),
    .line_filt(scl_f),
    .rise     (scl_rise),
    .fall     (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk      (clk),
    .rst      (rst),
    .line_raw (i2c_sda_i),
    .line_filt(sda_f),
    .rise     (sda_rise),
    .fall     (sda_fall)
  );

  // START/STOP judged against SCL as it was before any simultaneous edge.
  assign scl_was_high = (scl_f & ~scl_rise) | scl_fall;
  assign start_det    = sda_fall & scl_was_high;
  assign stop_det     = sda_rise & scl_was_high;
  assign byte_in      = {shift[6:0], sda_f};
  assign last_bit     = &bit_cnt;
  assign i2c_sda_o    = 1'b0;

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    ptr_n     = ptr;
    sda_t_n   = i2c_sda_t;
    wr_stb_n  = 1'b0;
    wr_addr_n = wr_addr;
    reg_we    = 1'b0;

    if (start_det) begin
      state_n   = ST_ADDR;
      bit_cnt_n = '0;
      sda_t_n   = NACK;
    end else if (stop_det) begin
      state_n = ST_IDLE;
      sda_t_n = NACK;
    end else begin
      case (state)
        ST_IDLE, ST_IGNORE: sda_t_n = NACK;

        ST_ADDR: begin
          sda_t_n = NACK;
          if (scl_rise) begin
            shift_n   = SHIFT_W'(byte_in);
            bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
            if (last_bit) begin
              if (byte_in[7:1] != DEV_ADDR) begin
                state_n = ST_IGNORE;
`ifdef I2C_TARGET_READ_EN
              end else begin
                state_n = ST_ACK_ADDR;
`else
              end else if (byte_in[0]) begin
                state_n = ST_IGNORE;
              end else begin
                state_n = ST_ACK_ADDR;
`endif
              end
            end
          end
        end

        // ACK states: pull low on the fall after the byte, leave on the ACK rise.
        ST_ACK_ADDR: begin
          if (scl_fall) begin
            sda_t_n = ACK;
          end else if (scl_rise) begin
            bit_cnt_n = '0;
`ifdef I2C_TARGET_READ_EN
            if (shift[0]) begin
              state_n = ST_RDATA;
              shift_n = regs[ptr];
            end else begin
              state_n = ST_PTR;
            end
`else
            state_n = ST_PTR;
`endif
          end
        end

        ST_PTR: begin
          if (scl_fall) sda_t_n = NACK;
          if (scl_rise) begin
            shift_n   = SHIFT_W'(byte_in);
            bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
            if (last_bit) begin
              ptr_n   = byte_in[AW-1:0];
              state_n = ST_ACK_PTR;
            end
          end
        end

        ST_ACK_PTR, ST_ACK_WDATA: begin
          if (scl_fall) begin
            sda_t_n = ACK;
          end else if (scl_rise) begin
            bit_cnt_n = '0;
            state_n   = ST_WDATA;
          end
        end

        ST_WDATA: begin
          if (scl_fall) sda_t_n = NACK;
          if (scl_rise) begin
            shift_n   = SHIFT_W'(byte_in);
            bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
            if (last_bit) begin
              reg_we    = 1'b1;
              wr_stb_n  = 1'b1;
              wr_addr_n = ptr;
              ptr_n     = ptr + AW'(1);
              state_n   = ST_ACK_WDATA;
            end
          end
        end

`ifdef I2C_TARGET_READ_EN
        ST_RDATA: begin
          if (scl_fall) begin
            sda_t_n = shift[7];
            shift_n = {shift[6:0], 1'b1};
          end else if (scl_rise) begin
            bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
            if (last_bit) begin
              ptr_n   = ptr + AW'(1);
              state_n = ST_MACK;
            end
          end
        end

        ST_MACK: begin
          if (scl_fall) begin
            sda_t_n = NACK;
          end else if (scl_rise) begin
            if (sda_f == ACK) begin
              shift_n   = regs[ptr];
              bit_cnt_n = '0;
              state_n   = ST_RDATA;
            end else begin
              state_n = ST_IGNORE;
            end
          end
        end
`endif

        default: begin
          state_n = ST_IDLE;
          sda_t_n = NACK;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      ptr       <= '0;
      i2c_sda_t <= 1'b1;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
    end else begin
      state     <= state_n;
      shift     <= shift_n;
      bit_cnt   <= bit_cnt_n;
      ptr       <= ptr_n;
      i2c_sda_t <= sda_t_n;
      wr_stb    <= wr_stb_n;
      wr_addr   <= wr_addr_n;
    end
  end

  // Register file; written in the same cycle the strobe goes out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else if (reg_we) begin
      regs[ptr] <= byte_in;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
    assign regs_o[8*k +: 8] = regs[k];
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Self-checking bench for i2c_reg_target: bit-banged I2C controller plus
// a register-file model; read tests run when I2C_TARGET_READ_EN is defined.
module tb_i2c_reg_target;

  localparam int unsigned NREG = 16;
  localparam int unsigned Q    = 6;
  localparam logic ACK_V  = 1'b0;
  localparam logic NACK_V = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic scl_gl = 1'b0;
  logic sda_m = 1'b1;
  logic glitch_on = 1'b0;
  logic sda_bus;

  logic               sda_o, sda_t, wr_stb;
  logic [NREG*8-1:0]  regs_o;
  logic [3:0]         wr_addr;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & (sda_t | sda_o);

  i2c_reg_target dut (
    .clk      (clk),
    .rst      (rst),
    .i2c_scl_i(scl ^ scl_gl),
    .i2c_sda_i(sda_bus),
    .i2c_sda_o(sda_o),
    .i2c_sda_t(sda_t),
    .regs_o   (regs_o),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr)
  );

  // Monitor: log every strobe cycle and count cycles with SDA pulled low.
  int unsigned stb_n = 0;
  int unsigned sda_low_n = 0;
  logic [3:0]  stb_addr [256];
  logic [7:0]  stb_data [256];

  always @(negedge clk) begin
    if (sda_t === 1'b0) sda_low_n <= sda_low_n + 1;
    if (wr_stb === 1'b1) begin
      if (stb_n < 256) begin
        stb_addr[stb_n] <= wr_addr;
        stb_data[stb_n] <= regs_o[8*wr_addr +: 8];
      end
      stb_n <= stb_n + 1;
    end
  end

  // Reference model of the register file
  logic [7:0]  m_regs [NREG];
  int unsigned m_ptr = 0;
  int unsigned exp_stb = 0;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  function automatic logic [127:0] m_flat();
    logic [127:0] f;
    for (int k = 0; k < NREG; k++) f[8*k +: 8] = m_regs[k];
    return f;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic glitch();
    if (glitch_on) begin
      scl_gl = 1'b1;
      tick(1);
      scl_gl = 1'b0;
    end else begin
      tick(1);
    end
  endtask

  task automatic put_bit(input logic b);
    tick(Q); sda_m = b;
    tick(2); glitch(); tick(Q - 3);
    scl = 1'b1;
    tick(Q); glitch(); tick(Q - 1);
    scl = 1'b0;
  endtask

  task automatic get_bit(output logic b);
    tick(Q); sda_m = 1'b1;
    tick(Q); scl = 1'b1;
    tick(Q); b = sda_bus;
    tick(Q); scl = 1'b0;
  endtask

  task automatic do_start();
    tick(Q); sda_m = 1'b1;
    tick(Q); scl = 1'b1;
    tick(Q); sda_m = 1'b0;
    tick(Q); scl = 1'b0;
  endtask

  task automatic do_stop();
    tick(Q); sda_m = 1'b0;
    tick(Q); scl = 1'b1;
    tick(Q); sda_m = 1'b1;
    tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      logic x;
      get_bit(x);
      b[i] = x;
    end
    put_bit(mack);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NREG; k++) m_regs[k] = 8'h00;
    m_ptr = 0;
  endtask

  task automatic xfer_write(input string tag, input logic [7:0] p, input int unsigned n,
                            input logic [7:0] d [4]);
    logic ack;
    int unsigned a;
    do_start();
    send_byte(8'hA0, ack);
    chk({tag, "/addr_ack"}, 128'(ack), 128'(ACK_V));
    send_byte(p, ack);
    chk({tag, "/ptr_ack"}, 128'(ack), 128'(ACK_V));
    a = p % NREG;
    for (int i = 0; i < n; i++) begin
      send_byte(d[i], ack);
      chk({tag, "/data_ack"}, 128'(ack), 128'(ACK_V));
      exp_stb++;
      chk({tag, "/stb_cnt"}, 128'(stb_n), 128'(exp_stb));
      chk({tag, "/wr_addr"}, 128'(stb_addr[exp_stb-1]), 128'(a));
      chk({tag, "/stb_regs"}, 128'(stb_data[exp_stb-1]), 128'(d[i]));
      m_regs[a] = d[i];
      a = (a + 1) % NREG;
    end
    m_ptr = a;
    do_stop();
    chk({tag, "/regs"}, regs_o, m_flat());
  endtask

`ifdef I2C_TARGET_READ_EN
  // Optional pointer write, then (repeated) START and a read of n bytes.
  task automatic xfer_read(input string tag, input logic set_ptr, input logic [7:0] p,
                           input int unsigned n);
    logic ack;
    logic [7:0] b;
    if (set_ptr) begin
      do_start();
      send_byte(8'hA0, ack);
      chk({tag, "/waddr_ack"}, 128'(ack), 128'(ACK_V));
      send_byte(p, ack);
      chk({tag, "/ptr_ack"}, 128'(ack), 128'(ACK_V));
      m_ptr = p % NREG;
    end
    do_start();
    send_byte(8'hA1, ack);
    chk({tag, "/raddr_ack"}, 128'(ack), 128'(ACK_V));
    for (int i = 0; i < n; i++) begin
      recv_byte((i == n - 1) ? NACK_V : ACK_V, b);
      chk({tag, "/rdata"}, 128'(b), 128'(m_regs[m_ptr]));
      m_ptr = (m_ptr + 1) % NREG;
    end
    tick(Q);
    chk({tag, "/released"}, 128'(sda_t), 128'(1'b1));
    do_stop();
    chk({tag, "/stb_none"}, 128'(stb_n), 128'(exp_stb));
  endtask
`endif

  initial begin
    logic [7:0]  d [4];
    logic        ack;
    int unsigned lo0, n;
    logic [7:0]  p;

    model_reset();
    tick(4);
    chk("rst/sda_t", 128'(sda_t), 128'(1'b1));
    chk("rst/sda_o", 128'(sda_o), 128'(1'b0));
    chk("rst/regs", regs_o, 128'(0));
    chk("rst/wr_stb", 128'(wr_stb), 128'(1'b0));
    chk("rst/wr_addr", 128'(wr_addr), 128'(0));
    rst = 1'b0;
    tick(10);

    d = '{8'h5A, 8'hC3, 8'h00, 8'h00};
    xfer_write("w_basic", 8'h03, 2, d);
    d = '{8'h11, 8'h22, 8'h00, 8'h00};
    xfer_write("w_wrap", 8'h0F, 2, d);

`ifdef I2C_TARGET_READ_EN
    xfer_read("r_basic", 1'b1, 8'h03, 2);
`else
    do_start();
    send_byte(8'hA0, ack);
    chk("r_off/waddr_ack", 128'(ack), 128'(ACK_V));
    send_byte(8'h03, ack);
    chk("r_off/ptr_ack", 128'(ack), 128'(ACK_V));
    do_start();
    lo0 = sda_low_n;
    send_byte(8'hA1, ack);
    chk("r_off/raddr_nack", 128'(ack), 128'(NACK_V));
    chk("r_off/never_low", 128'(sda_low_n), 128'(lo0));
    do_stop();
`endif

    // Foreign device address: never ACKed, never pulls SDA, no writes
    do_start();
    lo0 = sda_low_n;
    send_byte(8'hA2, ack);
    chk("foreign/addr_nack", 128'(ack), 128'(NACK_V));
    send_byte(8'h01, ack);
    chk("foreign/ptr_nack", 128'(ack), 128'(NACK_V));
    send_byte(8'hEE, ack);
    chk("foreign/never_low", 128'(sda_low_n), 128'(lo0));
    do_stop();
    chk("foreign/regs", regs_o, m_flat());
    chk("foreign/stb", 128'(stb_n), 128'(exp_stb));

    glitch_on = 1'b1;
    d = '{8'h3C, 8'h81, 8'h00, 8'h00};
    xfer_write("glitch", 8'h07, 2, d);
    glitch_on = 1'b0;

    for (int it = 0; it < 10; it++) begin
      p = 8'($urandom);
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      xfer_write("rand_w", p, n, d);
`ifdef I2C_TARGET_READ_EN
      xfer_read("rand_r", 1'b1, 8'($urandom), $urandom_range(1, 3));
      xfer_read("rand_cont", 1'b0, 8'h00, 1);
`endif
    end

    // Reset while SCL is high during bit 4 of a data byte
    do_start();
    send_byte(8'hA0, ack);
    chk("rst_mid/addr_ack", 128'(ack), 128'(ACK_V));
    send_byte(8'h05, ack);
    chk("rst_mid/ptr_ack", 128'(ack), 128'(ACK_V));
    put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
    tick(Q); sda_m = 1'b1;
    tick(Q); scl = 1'b1;
    tick(2); rst = 1'b1;
    tick(1);
    chk("rst_mid/sda_t", 128'(sda_t), 128'(1'b1));
    chk("rst_mid/regs", regs_o, 128'(0));
    rst = 1'b0;
    model_reset();
    tick(2 * Q - 3); scl = 1'b0;
    put_bit(1'b0); put_bit(1'b1); put_bit(1'b1); put_bit(1'b0);
    get_bit(ack);
    chk("rst_mid/nack", 128'(ack), 128'(NACK_V));
    chk("rst_mid/no_stb", 128'(stb_n), 128'(exp_stb));
    do_stop();
    chk("rst_mid/regs_after", regs_o, m_flat());

    // Reset while the target is driving the address ACK
    d = '{8'h9E, 8'h00, 8'h00, 8'h00};
    xfer_write("pre_ack_rst", 8'h02, 1, d);
    do_start();
    for (int i = 7; i >= 0; i--) put_bit(i == 7 || i == 5);
    tick(Q + 3);
    chk("rst_ack/driving", 128'(sda_t), 128'(1'b0));
    rst = 1'b1;
    tick(1);
    chk("rst_ack/released", 128'(sda_t), 128'(1'b1));
    chk("rst_ack/regs", regs_o, 128'(0));
    rst = 1'b0;
    model_reset();
    tick(Q); scl = 1'b1;
    tick(Q); scl = 1'b0;
    do_stop();

    d = '{8'hAA, 8'h55, 8'h00, 8'h00};
    xfer_write("post_rst", 8'h09, 2, d);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
